// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths and word/address types for the register file
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, live busy count and registered busy reads
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              s_busy,
    output logic              t_busy,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int N = 2 ** ADDR_W;
    logic [N-1:0] busy, busy_nx;
    logic         iss_ok, set, clr;
    // issue is applied after writeback so a same-address collision stays busy
    always_comb begin
        iss_ok  = iss && !(ZERO_REG && iss_rd == '0);
        set     = iss_ok && !busy[iss_rd];
        clr     = wrt && busy[rd] && !(iss_ok && iss_rd == rd);
        busy_nx = busy;
        if (wrt) busy_nx[rd] = 1'b0;
        if (iss_ok) busy_nx[iss_rd] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            s_busy   <= 1'b0;
            t_busy   <= 1'b0;
        end else begin
            busy     <= busy_nx;
            busy_cnt <= busy_cnt + (ADDR_W+1)'(set) - (ADDR_W+1)'(clr);
            s_busy   <= busy_nx[rs];
            t_busy   <= busy_nx[rt];
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 1W/2R register file with write-first registered reads and busy scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic [DATA_W-1:0] sout,
    output logic [DATA_W-1:0] tout,
    output logic              s_busy,
    output logic              t_busy,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int N = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] s_nx, t_nx;
    always_comb begin
        s_nx = (ZERO_REG && rs == '0) ? '0 : (wrt && rs == rd) ? din : mem[rs];
        t_nx = (ZERO_REG && rt == '0) ? '0 : (wrt && rt == rd) ? din : mem[rt];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            sout <= '0;
            tout <= '0;
        end else begin
            if (wrt && !(ZERO_REG && rd == '0)) mem[rd] <= din;
            sout <= s_nx;
            tout <= t_nx;
        end
    end
    regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd), .iss(iss), .iss_rd(iss_rd),
        .rs(rs), .rt(rt), .s_busy(s_busy), .t_busy(t_busy), .busy_cnt(busy_cnt)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus fill/drain sequences for regfile_sb
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0, wrt = 1'b0, iss = 1'b0;
    logic [5:0]  rd = '0, rs = '0, rt = '0, iss_rd = '0;
    logic [31:0] din = '0;
    logic [31:0] sout, tout;
    logic        s_busy, t_busy;
    logic [6:0]  busy_cnt;
    int errors = 0, checks = 0;
    typedef struct {
        logic        rst, wrt;
        logic [5:0]  rd;
        logic [31:0] din;
        logic [5:0]  rs, rt;
        logic        iss;
        logic [5:0]  iss_rd;
        logic [31:0] e_s, e_t;
        logic        e_sb, e_tb;
        logic [6:0]  e_cnt;
    } vec_t;
    vec_t v [17];
    always #5 clk = ~clk;
    regfile_sb dut (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd), .din(din), .rs(rs), .rt(rt),
        .iss(iss), .iss_rd(iss_rd), .sout(sout), .tout(tout),
        .s_busy(s_busy), .t_busy(t_busy), .busy_cnt(busy_cnt)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic step(input logic r, input logic w, input logic [5:0] d, input logic [31:0] x,
                        input logic [5:0] s, input logic [5:0] t, input logic i, input logic [5:0] ir);
        @(negedge clk);
        rst = r; wrt = w; rd = d; din = x; rs = s; rt = t; iss = i; iss_rd = ir;
        @(posedge clk);
        #1;
    endtask
    initial begin
        //        rst  wrt rd  din           rs  rt  iss ir  e_s           e_t           sb tb cnt
        v[0]  = '{1, 0, 0,  32'h0,        5,  5,  0, 0,  32'h0,        32'h0,        0, 0, 0};
        v[1]  = '{0, 1, 5,  32'hDEADBEEF, 5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
        v[2]  = '{1, 0, 0,  32'h0,        5,  5,  0, 0,  32'h0,        32'h0,        0, 0, 0};
        v[3]  = '{0, 0, 0,  32'h0,        5,  5,  0, 0,  32'h0,        32'h0,        0, 0, 0};
        v[4]  = '{0, 1, 7,  32'h12345678, 7,  7,  0, 0,  32'h12345678, 32'h12345678, 0, 0, 0};
        v[5]  = '{0, 1, 0,  32'hFFFFFFFF, 0,  7,  1, 0,  32'h0,        32'h12345678, 0, 0, 0};
        v[6]  = '{0, 0, 0,  32'h0,        3,  0,  1, 3,  32'h0,        32'h0,        1, 0, 1};
        v[7]  = '{0, 0, 0,  32'h0,        3,  4,  1, 4,  32'h0,        32'h0,        1, 1, 2};
        v[8]  = '{0, 1, 3,  32'hA5,       3,  4,  0, 0,  32'hA5,       32'h0,        0, 1, 1};
        v[9]  = '{0, 0, 0,  32'h0,        9,  4,  1, 9,  32'h0,        32'h0,        1, 1, 2};
        v[10] = '{0, 1, 9,  32'h55,       9,  9,  1, 9,  32'h55,       32'h55,       1, 1, 2};
        v[11] = '{0, 0, 0,  32'h0,        4,  9,  1, 4,  32'h0,        32'h55,       1, 1, 2};
        v[12] = '{0, 1, 5,  32'h1,        5,  3,  0, 0,  32'h1,        32'hA5,       0, 0, 2};
        v[13] = '{0, 1, 4,  32'h44,       4,  11, 1, 11, 32'h44,       32'h0,        0, 1, 2};
        v[14] = '{0, 0, 0,  32'h0,        9,  11, 0, 0,  32'h55,       32'h0,        1, 1, 2};
        v[15] = '{1, 1, 13, 32'h7,        9,  13, 1, 12, 32'h0,        32'h0,        0, 0, 0};
        v[16] = '{0, 0, 0,  32'h0,        9,  13, 0, 0,  32'h0,        32'h0,        0, 0, 0};
        for (int k = 0; k < 17; k++) begin
            step(v[k].rst, v[k].wrt, v[k].rd, v[k].din, v[k].rs, v[k].rt, v[k].iss, v[k].iss_rd);
            chk($sformatf("v%0d sout", k), sout, v[k].e_s);
            chk($sformatf("v%0d tout", k), tout, v[k].e_t);
            chk($sformatf("v%0d s_busy", k), 32'(s_busy), 32'(v[k].e_sb));
            chk($sformatf("v%0d t_busy", k), 32'(t_busy), 32'(v[k].e_tb));
            chk($sformatf("v%0d busy_cnt", k), 32'(busy_cnt), 32'(v[k].e_cnt));
        end
        for (int i = 1; i < 64; i++) begin
            step(0, 0, 0, 0, 6'(i), 0, 1, 6'(i));
            chk($sformatf("fill%0d cnt", i), 32'(busy_cnt), i);
        end
        chk("fill s_busy", 32'(s_busy), 1);
        step(0, 0, 0, 0, 1, 0, 1, 1);
        chk("reissue cnt", 32'(busy_cnt), 63);
        chk("reissue zero t_busy", 32'(t_busy), 0);
        for (int i = 1; i < 64; i++) begin
            step(0, 1, 6'(i), 32'(i * 3), 6'(i), 6'(i), 0, 0);
            chk($sformatf("drain%0d cnt", i), 32'(busy_cnt), 63 - i);
            chk($sformatf("drain%0d sout", i), sout, 32'(i * 3));
        end
        step(0, 1, 5, 32'h99, 63, 1, 0, 0);
        chk("extra wrt cnt", 32'(busy_cnt), 0);
        chk("r63 sout", sout, 32'd189);
        chk("r1 tout", tout, 32'd3);
        chk("r1 t_busy", 32'(t_busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
